// File: rtl/ps2_pkg.sv
// ps2_pkg: scancodes, arrow-key bit positions and FSM encodings shared by the PS/2 receiver and decoder.
package ps2_pkg;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam int KEY_UP    = 0;
  localparam int KEY_DOWN  = 1;
  localparam int KEY_LEFT  = 2;
  localparam int KEY_RIGHT = 3;
  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {D_IDLE, D_EXT, D_BRK, D_EXT_BRK} dec_state_t;
  function automatic logic [3:0] arrow_mask(input logic [7:0] b);
    arrow_mask = '0;
    arrow_mask[KEY_UP]    = b == SC_UP;
    arrow_mask[KEY_DOWN]  = b == SC_DOWN;
    arrow_mask[KEY_LEFT]  = b == SC_LEFT;
    arrow_mask[KEY_RIGHT] = b == SC_RIGHT;
  endfunction
endpackage

// File: rtl/ps2_rx.sv
// ps2_rx: synchronizes PS/2 clock/data, receives 11-bit frames with idle timeout.
// Parity is enforced only when PS2_PARITY_CHECK_EN is defined.
module ps2_rx import ps2_pkg::*; #(
  parameter int TIMEOUT_CYCLES = 65000
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [1:0] clk_s, data_s;
  logic clk_d, fall, sbit, tout, good, stop_ok;
  logic [2:0] cnt;
  logic [7:0] shreg;
  logic par;
  logic [CW-1:0] idle_cnt;
  rx_state_t state, state_n;
  assign sbit = data_s[1];
  assign fall = clk_d & ~clk_s[1];
  assign tout = !fall && state != RX_IDLE && idle_cnt == CW'(TIMEOUT_CYCLES);
`ifdef PS2_PARITY_CHECK_EN
  assign good = sbit & ^{shreg, par};
`else
  assign good = sbit;
`endif
  assign stop_ok = fall && state == RX_STOP && good;
  always_comb begin
    state_n = tout ? RX_IDLE : !fall ? state :
              state == RX_IDLE   ? (sbit ? RX_IDLE : RX_DATA) :
              state == RX_DATA   ? (cnt == 3'd7 ? RX_PARITY : RX_DATA) :
              state == RX_PARITY ? RX_STOP : RX_IDLE;
  end
  always_ff @(posedge pclk) begin
    if (rst) begin
      clk_s     <= 2'b11;
      data_s    <= 2'b11;
      clk_d     <= 1'b1;
      state     <= RX_IDLE;
      cnt       <= '0;
      shreg     <= '0;
      par       <= 1'b0;
      idle_cnt  <= '0;
      rx_byte   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      clk_s     <= {clk_s[0], ps2_clk};
      data_s    <= {data_s[0], ps2_data};
      clk_d     <= clk_s[1];
      state     <= state_n;
      idle_cnt  <= fall ? '0 : idle_cnt == CW'(TIMEOUT_CYCLES) ? idle_cnt : idle_cnt + CW'(1);
      rx_valid  <= stop_ok;
      frame_err <= (fall && state == RX_STOP && !good) || tout;
      if (stop_ok) rx_byte <= shreg;
      if (fall && state == RX_IDLE) cnt <= '0;
      if (fall && state == RX_DATA) begin
        shreg <= {sbit, shreg[7:1]};
        cnt   <= cnt + 3'd1;
      end
      if (fall && state == RX_PARITY) par <= sbit;
    end
  end
endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: turns PS/2 scancodes into a held arrow-key mask (UP, DOWN, LEFT, RIGHT).
// Optional macro PS2_PARITY_CHECK_EN enables parity rejection in ps2_rx.
module ps2_key_decoder import ps2_pkg::*; #(
  parameter int TIMEOUT_CYCLES = 65000
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [3:0] key,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err
);
  dec_state_t state, state_n;
  logic [3:0] key_n, mask;
  ps2_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .pclk(pclk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .rx_byte(rx_byte), .rx_valid(rx_valid), .frame_err(frame_err)
  );
  assign mask = arrow_mask(rx_byte);
  always_comb begin
    state_n = state;
    key_n   = key;
    if (rx_valid)
      case (state)
        D_IDLE:    state_n = rx_byte == SC_EXT ? D_EXT : rx_byte == SC_BRK ? D_BRK : D_IDLE;
        D_EXT: begin
          state_n = rx_byte == SC_EXT ? D_EXT : rx_byte == SC_BRK ? D_EXT_BRK : D_IDLE;
          key_n   = rx_byte == SC_BRK ? key : key | mask;
        end
        D_EXT_BRK: begin
          state_n = D_IDLE;
          key_n   = key & ~mask;
        end
        default:   state_n = D_IDLE;
      endcase
  end
  always_ff @(posedge pclk) begin
    if (rst) begin
      state <= D_IDLE;
      key   <= '0;
    end else begin
      state <= state_n;
      key   <= key_n;
    end
  end
endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: directed PS/2 frames against hand-computed key/byte/pulse expectations.
module tb_ps2_key_decoder;
  localparam int TO = 300;
  localparam int HALF = 20;
  logic pclk = 0, rst = 1, ps2_clk = 1, ps2_data = 1;
  logic [3:0] key;
  logic [7:0] rx_byte;
  logic rx_valid, frame_err;
  int vectors = 0, errors = 0;
  int nvalid = 0, nerr = 0;
  logic rv_d = 0;
  logic [3:0] key_at_valid = '0, key_after = '0;

  ps2_key_decoder #(.TIMEOUT_CYCLES(TO)) dut (
    .pclk(pclk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .key(key), .rx_byte(rx_byte), .rx_valid(rx_valid), .frame_err(frame_err)
  );

  always #5 pclk = ~pclk;

  always @(negedge pclk) begin
    if (rv_d) key_after = key;
    if (rx_valid) begin
      nvalid++;
      key_at_valid = key;
    end
    if (frame_err) nerr++;
    rv_d = rx_valid;
  end

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      repeat (HALF) @(posedge pclk);
      ps2_clk = 0;
      repeat (HALF) @(posedge pclk);
      ps2_clk = 1;
    end
  endtask

  task automatic frame(input logic [7:0] b, input logic bad_par = 0, input logic stop = 1);
    send_bits({stop, ~^b ^ bad_par, b, 1'b0}, 11);
    ps2_data = 1;
    repeat (30) @(posedge pclk);
  endtask

  task automatic chk_key(input string name, input logic [3:0] exp);
    @(negedge pclk);
    vectors++;
    if (key !== exp) begin
      errors++;
      $display("FAIL %s: key=%b expected %b", name, key, exp);
    end
  endtask

  task automatic chk_cnt(input string name, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic test_reset;
    @(negedge pclk);
    vectors += 4;
    if (key !== 4'b0000) begin errors++; $display("FAIL reset_key: key=%b expected 0000", key); end
    if (rx_byte !== 8'h00) begin errors++; $display("FAIL reset_byte: rx_byte=%h expected 00", rx_byte); end
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: rx_valid=%b expected 0", rx_valid); end
    if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_err: frame_err=%b expected 0", frame_err); end
  endtask

  task automatic test_make;
    int v0;
    v0 = nvalid;
    frame(8'hE0);
    chk_key("make_after_e0", 4'b0000);
    frame(8'h75);
    chk_cnt("make_valid_pulses", nvalid - v0, 2);
    vectors += 3;
    if (rx_byte !== 8'h75) begin errors++; $display("FAIL make_byte: rx_byte=%h expected 75", rx_byte); end
    if (key_at_valid !== 4'b0000) begin errors++; $display("FAIL make_key_during_valid: key=%b expected 0000", key_at_valid); end
    if (key_after !== 4'b0001) begin errors++; $display("FAIL make_key_after_valid: key=%b expected 0001", key_after); end
  endtask

  task automatic test_sequence;
    frame(8'hE0); frame(8'h74);
    chk_key("seq_right", 4'b1001);
    frame(8'hE0); frame(8'h75);
    chk_key("seq_typematic", 4'b1001);
    frame(8'hE0); frame(8'hF0); frame(8'h75);
    chk_key("seq_up_release", 4'b1000);
    frame(8'h75);
    chk_key("seq_nonext_make", 4'b1000);
    frame(8'hF0); frame(8'h74);
    chk_key("seq_nonext_break", 4'b1000);
    frame(8'hE0); frame(8'h72);
    chk_key("seq_down_added", 4'b1010);
    frame(8'hE0); frame(8'hF0); frame(8'h74);
    frame(8'hE0); frame(8'hF0); frame(8'h72);
    chk_key("seq_all_released", 4'b0000);
  endtask

  task automatic test_parity;
    int v0, e0;
    v0 = nvalid; e0 = nerr;
    frame(8'h75, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
    chk_cnt("parity_err", nerr - e0, 1);
    chk_cnt("parity_no_valid", nvalid - v0, 0);
    vectors++;
    if (rx_byte !== 8'h72) begin errors++; $display("FAIL parity_byte_kept: rx_byte=%h expected 72", rx_byte); end
`else
    chk_cnt("parity_no_err", nerr - e0, 0);
    chk_cnt("parity_valid", nvalid - v0, 1);
    vectors++;
    if (rx_byte !== 8'h75) begin errors++; $display("FAIL parity_byte: rx_byte=%h expected 75", rx_byte); end
`endif
    chk_key("parity_key", 4'b0000);
  endtask

  task automatic test_stop;
    int v0, e0;
    logic [7:0] prev;
    prev = rx_byte;
    v0 = nvalid; e0 = nerr;
    frame(8'h29, 1'b0, 1'b0);
    chk_cnt("stop_err", nerr - e0, 1);
    chk_cnt("stop_no_valid", nvalid - v0, 0);
    vectors++;
    if (rx_byte !== prev) begin errors++; $display("FAIL stop_byte_kept: rx_byte=%h expected %h", rx_byte, prev); end
  endtask

  task automatic test_timeout;
    int v0, e0;
    v0 = nvalid; e0 = nerr;
    send_bits({3'b111, 8'h1C, 1'b0}, 5);
    ps2_data = 1;
    repeat (TO + 50) @(posedge pclk);
    chk_cnt("timeout_err", nerr - e0, 1);
    chk_cnt("timeout_no_valid", nvalid - v0, 0);
    frame(8'h1C);
    chk_cnt("timeout_recover_valid", nvalid - v0, 1);
    chk_cnt("timeout_no_extra_err", nerr - e0, 1);
    vectors++;
    if (rx_byte !== 8'h1C) begin errors++; $display("FAIL timeout_byte: rx_byte=%h expected 1c", rx_byte); end
  endtask

  task automatic test_reset_mid;
    int e0;
    frame(8'hE0); frame(8'h75);
    frame(8'hE0); frame(8'h72);
    chk_key("rstmid_setup", 4'b0011);
    send_bits({3'b111, 8'hE0, 1'b0}, 4);
    @(posedge pclk); rst = 1;
    repeat (3) @(posedge pclk); rst = 0;
    chk_key("rstmid_key_cleared", 4'b0000);
    vectors++;
    if (rx_byte !== 8'h00) begin errors++; $display("FAIL rstmid_byte: rx_byte=%h expected 00", rx_byte); end
    e0 = nerr;
    frame(8'hE0); frame(8'h6B);
    chk_key("rstmid_left", 4'b0100);
    chk_cnt("rstmid_no_err", nerr - e0, 0);
  endtask

  initial begin
    repeat (5) @(posedge pclk);
    rst = 0;
    test_reset;
    test_make;
    test_sequence;
    test_parity;
    test_stop;
    test_timeout;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
